// File: rtl/calc_mem_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package calc_mem_pkg;

    typedef enum logic [1:0] {SRC_NONE, SRC_VGA, SRC_CPU, SRC_KBD} mem_src_t;

    localparam int STARVE_MAX_DEFAULT = 8;
    localparam int KBD_DATA_W         = 5;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive lost arbitration cycles for one requester.
module starve_counter #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign sat = (cnt_q == CW'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between VGA, CPU and keyboard masters with
// fixed priority, starvation promotion and tag-routed read returns.
module dmem_port_arbiter
    import calc_mem_pkg::*;
#(
    parameter int             BUS        = 32,
    parameter logic [BUS-1:0] KBD_ADDR   = '0,
    parameter int             STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vga_req,
    input  logic [BUS-1:0]        vga_addr,
    output logic                  vga_gnt,
    output logic                  vga_rvalid,
    output logic [BUS-1:0]        vga_rdata,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [BUS-1:0]        cpu_addr,
    input  logic [BUS-1:0]        cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [BUS-1:0]        cpu_rdata,
    input  logic                  kbd_req,
    input  logic [KBD_DATA_W-1:0] kbd_data,
    output logic                  kbd_gnt,
    output logic [BUS-1:0]        mem_addr,
    output logic [BUS-1:0]        mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [BUS-1:0]        mem_rdata
);

    localparam int NUM_ST = 2;
    localparam int ST_CPU = 0;
    localparam int ST_KBD = 1;

    logic           vga_gnt_q, vga_gnt_d;
    logic           cpu_gnt_q, cpu_gnt_d;
    logic           kbd_gnt_q, kbd_gnt_d;
    logic           mem_we_q, mem_we_d;
    logic           mem_re_q, mem_re_d;
    logic [BUS-1:0] mem_addr_q, mem_addr_d;
    logic [BUS-1:0] mem_wdata_q, mem_wdata_d;
    mem_src_t       rd_tag_q, rd_tag_d;
    mem_src_t       ret_tag_q;
    logic [BUS-1:0] vga_rdata_q, cpu_rdata_q;

    logic              vga_elig, cpu_elig, kbd_elig;
    mem_src_t          win;
    logic [NUM_ST-1:0] st_req, st_elig, st_win, st_inc, st_clr, st_sat;

    // A requester is still holding its old request during its own grant cycle.
    assign vga_elig = vga_req & ~vga_gnt_q;
    assign cpu_elig = cpu_req & ~cpu_gnt_q;
    assign kbd_elig = kbd_req & ~kbd_gnt_q;

    assign st_req  = {kbd_req, cpu_req};
    assign st_elig = {kbd_elig, cpu_elig};
    assign st_win  = {win == SRC_KBD, win == SRC_CPU};

    generate
        for (genvar gi = 0; gi < NUM_ST; gi++) begin : gen_starve
            assign st_inc[gi] = st_elig[gi] & ~st_win[gi];
            assign st_clr[gi] = ~st_req[gi] | st_win[gi];

            starve_counter #(
                .MAX (STARVE_MAX)
            ) u_starve (
                .clk   (clk),
                .reset (reset),
                .inc   (st_inc[gi]),
                .clr   (st_clr[gi]),
                .sat   (st_sat[gi])
            );
        end
    endgenerate

    // Promoted keyboard beats promoted CPU, which beats the VGA default.
    always_comb begin
        win = SRC_NONE;
        if (kbd_elig && st_sat[ST_KBD]) begin
            win = SRC_KBD;
        end else if (cpu_elig && st_sat[ST_CPU]) begin
            win = SRC_CPU;
        end else if (vga_elig) begin
            win = SRC_VGA;
        end else if (cpu_elig) begin
            win = SRC_CPU;
        end else if (kbd_elig) begin
            win = SRC_KBD;
        end
    end

    always_comb begin
        vga_gnt_d   = 1'b0;
        cpu_gnt_d   = 1'b0;
        kbd_gnt_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_tag_d    = SRC_NONE;
        case (win)
            SRC_VGA: begin
                vga_gnt_d  = 1'b1;
                mem_re_d   = 1'b1;
                mem_addr_d = vga_addr;
                rd_tag_d   = SRC_VGA;
            end
            SRC_CPU: begin
                cpu_gnt_d   = 1'b1;
                mem_we_d    = cpu_we;
                mem_re_d    = ~cpu_we;
                mem_addr_d  = cpu_addr;
                mem_wdata_d = cpu_wdata;
                rd_tag_d    = cpu_we ? SRC_NONE : SRC_CPU;
            end
            SRC_KBD: begin
                kbd_gnt_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = KBD_ADDR;
                mem_wdata_d = {{(BUS - KBD_DATA_W){1'b0}}, kbd_data};
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_gnt_q   <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            kbd_gnt_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_tag_q    <= SRC_NONE;
            ret_tag_q   <= SRC_NONE;
            vga_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            vga_gnt_q   <= vga_gnt_d;
            cpu_gnt_q   <= cpu_gnt_d;
            kbd_gnt_q   <= kbd_gnt_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_tag_q    <= rd_tag_d;
            ret_tag_q   <= rd_tag_q;
            if (ret_tag_q == SRC_VGA) begin
                vga_rdata_q <= mem_rdata;
            end
            if (ret_tag_q == SRC_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    // Memory data arrives in the return cycle; the owner sees it then and keeps it afterwards.
    assign vga_rvalid = (ret_tag_q == SRC_VGA);
    assign cpu_rvalid = (ret_tag_q == SRC_CPU);
    assign vga_rdata  = vga_rvalid ? mem_rdata : vga_rdata_q;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;

    assign vga_gnt   = vga_gnt_q;
    assign cpu_gnt   = cpu_gnt_q;
    assign kbd_gnt   = kbd_gnt_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed checks of dmem_port_arbiter against a cycle-level reference model.
module tb_dmem_port_arbiter;

    localparam int          SMAX  = 8;
    localparam logic [31:0] KADDR = 32'h0000_0FF0;
    localparam int          NONE  = 0;
    localparam int          V     = 1;
    localparam int          C     = 2;
    localparam int          K     = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_req, cpu_req, cpu_we, kbd_req;
    logic [31:0] vga_addr, cpu_addr, cpu_wdata, mem_rdata;
    logic [4:0]  kbd_data;
    logic        vga_gnt, vga_rvalid, cpu_gnt, cpu_rvalid, kbd_gnt, mem_we, mem_re;
    logic [31:0] vga_rdata, cpu_rdata, mem_addr, mem_wdata;

    dmem_port_arbiter #(
        .BUS        (32),
        .KBD_ADDR   (KADDR),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .kbd_req    (kbd_req),
        .kbd_data   (kbd_data),
        .kbd_gnt    (kbd_gnt),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] cpu_cnt, kbd_cnt;
    assign cpu_cnt = 32'(dut.gen_starve[0].u_starve.cnt_q);
    assign kbd_cnt = 32'(dut.gen_starve[1].u_starve.cnt_q);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: what each output should read in the current cycle.
    int          m_starve_c, m_starve_k, m_rd_owner, m_ret_owner;
    bit          m_gv, m_gc, m_gk, m_we, m_re;
    logic [31:0] m_addr, m_wdata, m_hold_v, m_hold_c;

    int          pv, pc, pk;
    bit          auto_drive, v_done, c_done, k_done, mem_fixed;
    logic [31:0] mem_next;

    task automatic model_clear();
        m_starve_c = 0; m_starve_k = 0; m_rd_owner = NONE; m_ret_owner = NONE;
        m_gv = 0; m_gc = 0; m_gk = 0; m_we = 0; m_re = 0;
        m_addr = '0; m_wdata = '0; m_hold_v = '0; m_hold_c = '0;
    endtask

    // Called at the active edge, while inputs still hold the values of the ending cycle.
    task automatic model_edge();
        bit ev, ec, ek;
        int w;
        if (!reset) begin
            model_clear();
            return;
        end
        if (m_ret_owner == V) m_hold_v = mem_rdata;
        if (m_ret_owner == C) m_hold_c = mem_rdata;
        ev = vga_req && !m_gv;
        ec = cpu_req && !m_gc;
        ek = kbd_req && !m_gk;
        w = NONE;
        if (ek && m_starve_k >= SMAX)      w = K;
        else if (ec && m_starve_c >= SMAX) w = C;
        else if (ev)                       w = V;
        else if (ec)                       w = C;
        else if (ek)                       w = K;
        if (!cpu_req || w == C) m_starve_c = 0;
        else if (ec && m_starve_c < SMAX) m_starve_c++;
        if (!kbd_req || w == K) m_starve_k = 0;
        else if (ek && m_starve_k < SMAX) m_starve_k++;
        m_ret_owner = m_rd_owner;
        m_rd_owner  = NONE;
        m_gv = (w == V); m_gc = (w == C); m_gk = (w == K);
        m_we = 0; m_re = 0;
        case (w)
            V: begin m_re = 1; m_addr = vga_addr; m_rd_owner = V; end
            C: begin
                m_addr = cpu_addr; m_wdata = cpu_wdata;
                if (cpu_we) m_we = 1;
                else begin m_re = 1; m_rd_owner = C; end
            end
            K: begin m_we = 1; m_addr = KADDR; m_wdata = {27'b0, kbd_data}; end
            default: ;
        endcase
    endtask

    task automatic check_all();
        check_eq("vga_gnt", 32'(vga_gnt), 32'(m_gv));
        check_eq("cpu_gnt", 32'(cpu_gnt), 32'(m_gc));
        check_eq("kbd_gnt", 32'(kbd_gnt), 32'(m_gk));
        check_eq("mem_we", 32'(mem_we), 32'(m_we));
        check_eq("mem_re", 32'(mem_re), 32'(m_re));
        check_eq("we_re_excl", 32'(mem_we & mem_re), 32'd0);
        check_eq("mem_addr", mem_addr, m_addr);
        check_eq("mem_wdata", mem_wdata, m_wdata);
        check_eq("vga_rvalid", 32'(vga_rvalid), 32'(m_ret_owner == V));
        check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(m_ret_owner == C));
        check_eq("vga_rdata", vga_rdata, (m_ret_owner == V) ? mem_rdata : m_hold_v);
        check_eq("cpu_rdata", cpu_rdata, (m_ret_owner == C) ? mem_rdata : m_hold_c);
        check_eq("starve_cpu", cpu_cnt, 32'(m_starve_c));
        check_eq("starve_kbd", kbd_cnt, 32'(m_starve_k));
    endtask

    task automatic new_vga();
        vga_req  = ($urandom_range(0, 99) < pv);
        vga_addr = $urandom;
    endtask

    task automatic new_cpu();
        cpu_req   = ($urandom_range(0, 99) < pc);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
    endtask

    task automatic new_kbd();
        kbd_req  = ($urandom_range(0, 99) < pk);
        kbd_data = 5'($urandom);
    endtask

    // Each master holds its request until granted, keeps it stale through the
    // grant cycle, then issues something new.
    task automatic drive_auto();
        if (v_done) begin v_done = 0; new_vga(); end
        else if (m_gv) v_done = 1;
        else if (!vga_req) new_vga();
        if (c_done) begin c_done = 0; new_cpu(); end
        else if (m_gc) c_done = 1;
        else if (!cpu_req) new_cpu();
        if (k_done) begin k_done = 0; new_kbd(); end
        else if (m_gk) k_done = 1;
        else if (!kbd_req) new_kbd();
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (mem_fixed) begin
            mem_rdata = mem_next;
            mem_fixed = 0;
        end else begin
            mem_rdata = $urandom;
        end
        if (auto_drive) drive_auto();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        bit          found;
        logic [31:0] peak;
        reset = 0;
        vga_req = 0; vga_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        kbd_req = 0; kbd_data = '0; mem_rdata = '0;
        auto_drive = 0; v_done = 0; c_done = 0; k_done = 0; mem_fixed = 0; mem_next = '0;
        pv = 0; pc = 0; pk = 0;
        model_clear();
        repeat (2) step();
        check_eq("rst_mem_addr", mem_addr, 32'd0);

        // Reset while a VGA read is in flight
        reset = 1;
        vga_req = 1; vga_addr = 32'h40;
        step();
        check_eq("rmr_gnt", 32'(vga_gnt), 32'd1);
        vga_req = 0;
        reset = 0;
        model_clear();
        #1;
        check_all();
        check_eq("rmr_gnt_cleared", 32'(vga_gnt), 32'd0);
        step();
        check_eq("rmr_no_rvalid", 32'(vga_rvalid), 32'd0);
        reset = 1;
        vga_req = 1; vga_addr = 32'h44;
        step();
        check_eq("rmr_regrant", 32'(vga_gnt), 32'd1);
        check_eq("rmr_regrant_addr", mem_addr, 32'h44);
        vga_req = 0;
        step();

        // Single VGA read with known memory data
        vga_req = 1; vga_addr = 32'h10;
        step();
        check_eq("vrd_gnt", 32'(vga_gnt), 32'd1);
        check_eq("vrd_re", 32'(mem_re), 32'd1);
        check_eq("vrd_addr", mem_addr, 32'h10);
        vga_req = 0;
        mem_next = 32'hCAFE_0001; mem_fixed = 1;
        step();
        check_eq("vrd_rvalid", 32'(vga_rvalid), 32'd1);
        check_eq("vrd_rdata", vga_rdata, 32'hCAFE_0001);
        step();
        check_eq("vrd_rdata_held", vga_rdata, 32'hCAFE_0001);

        // Lone CPU store
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678;
        step();
        check_eq("cst_gnt", 32'(cpu_gnt), 32'd1);
        check_eq("cst_we", 32'(mem_we), 32'd1);
        check_eq("cst_addr", mem_addr, 32'h20);
        check_eq("cst_wdata", mem_wdata, 32'h1234_5678);
        cpu_req = 0;
        step();
        check_eq("cst_no_rvalid", 32'(cpu_rvalid), 32'd0);

        // All three request together
        vga_req = 1; vga_addr = 32'h30;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h34;
        kbd_req = 1; kbd_data = 5'h1F;
        step();
        check_eq("all3_vga_first", 32'(vga_gnt), 32'd1);
        vga_req = 0;
        step();
        check_eq("all3_cpu_second", 32'(cpu_gnt), 32'd1);
        cpu_req = 0;
        step();
        check_eq("all3_kbd_third", 32'(kbd_gnt), 32'd1);
        check_eq("all3_kbd_wdata", mem_wdata, 32'h0000_001F);
        check_eq("all3_kbd_addr", mem_addr, KADDR);
        kbd_req = 0;
        step();

        // Interleaved VGA then CPU loads
        vga_req = 1; vga_addr = 32'h50;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h54;
        step();
        vga_req = 0;
        mem_next = 32'hAAAA_0050; mem_fixed = 1;
        step();
        cpu_req = 0;
        check_eq("il_vga_rvalid", 32'(vga_rvalid), 32'd1);
        check_eq("il_vga_rdata", vga_rdata, 32'hAAAA_0050);
        check_eq("il_cpu_quiet", 32'(cpu_rvalid), 32'd0);
        mem_next = 32'hBBBB_0054; mem_fixed = 1;
        step();
        check_eq("il_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check_eq("il_cpu_rdata", cpu_rdata, 32'hBBBB_0054);
        check_eq("il_vga_quiet", 32'(vga_rvalid), 32'd0);
        check_eq("il_vga_held", vga_rdata, 32'hAAAA_0050);
        step();

        // KBD starved by a continuous VGA/CPU stream
        vga_req = 1; vga_addr = $urandom;
        cpu_req = 1; cpu_we = 0; cpu_addr = $urandom; cpu_wdata = $urandom;
        kbd_req = 1; kbd_data = 5'h0A;
        pv = 100; pc = 100; pk = 0;
        auto_drive = 1;
        found = 0;
        peak = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (kbd_cnt > peak) peak = kbd_cnt;
            if (kbd_gnt) begin
                found = 1;
                check_eq("stv_cnt_after_gnt", kbd_cnt, 32'd0);
            end
        end
        check_eq("stv_kbd_granted", 32'(found), 32'd1);
        check_eq("stv_peak", peak, 32'(SMAX));

        // Random traffic with varying request densities
        for (int p = 0; p < 8; p++) begin
            if (p == 0) begin
                pv = 100; pc = 100; pk = 100;
            end else begin
                pv = $urandom_range(0, 100);
                pc = $urandom_range(0, 100);
                pk = $urandom_range(0, 100);
            end
            repeat (200) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between three requesters: the VGA frame reader, the processor load/store path, and the keyboard scan-code writer.
- Sits between those masters and the data memory, and replaces the current hard-wired split of memory ports.
- Arbitration is fixed priority (VGA > CPU > KBD) with starvation promotion for CPU and KBD.
- Memory commands are registered; read data returns with a known, fixed latency.

Parameters:
- bus, 32, data and address width.
- KBD_ADDR, 32'd0, word address written by keyboard requests.
- STARVE_MAX, 8, number of consecutive lost cycles after which a waiting CPU or KBD request is promoted to top priority.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- vga_req  in  1  VGA read request.
- vga_addr  in  bus  VGA read address.
- vga_gnt  out  1  VGA command issued this cycle.
- vga_rvalid  out  1  VGA read data valid.
- vga_rdata  out  bus  VGA read data.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  bus  CPU address.
- cpu_wdata  in  bus  CPU store data.
- cpu_gnt  out  1  CPU command issued this cycle.
- cpu_rvalid  out  1  CPU load data valid.
- cpu_rdata  out  bus  CPU load data.
- kbd_req  in  1  keyboard write request.
- kbd_data  in  5  scan code.
- kbd_gnt  out  1  KBD write issued this cycle.
- mem_addr  out  bus  memory address.
- mem_wdata  out  bus  memory write data.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_rdata  in  bus  memory read data, valid one cycle after mem_re.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears all gnt, rvalid, mem_we and mem_re.
  - Clears mem_addr, mem_wdata and all rdata to 0.
  - Clears both starvation counters and the read-tag pipeline.
  - An in-flight read is dropped and no rvalid is produced for it. Normal operation resumes on the first clock edge after reset deasserts.
- Requester protocol:
  - A requester raises req with addr/data/we stable and holds them until it sees its gnt=1.
  - It drops req, or presents a new request, in the cycle after gnt.
- Arbitration (cycle t): among eligible requesters, one winner is chosen.
  - A requester whose gnt is 1 in cycle t is ineligible in cycle t, because its req is stale.
  - Default priority is VGA > CPU > KBD.
  - If starve_kbd reaches STARVE_MAX, KBD ranks above VGA and CPU.
  - Otherwise, if starve_cpu reaches STARVE_MAX, CPU ranks above VGA.
  - If both saturate, KBD wins first.
- Issue (registered, cycle t+1):
  - The winner's gnt=1 for exactly one cycle.
  - mem_addr and mem_wdata take the winner's values. KBD uses KBD_ADDR and wdata = {27'b0, kbd_data}.
  - mem_we = 1 for a CPU store or a KBD write; mem_re = 1 for a CPU load or a VGA read.
  - With no winner, mem_we = mem_re = 0 and mem_addr/mem_wdata hold their previous values.
- Read return (cycle t+2):
  - A 2-bit tag registered alongside mem_re routes mem_rdata to the owning requester.
  - The owner's rvalid = 1 for one cycle and its rdata is registered and held until the next rvalid.
  - Total latency is req sampled at t, gnt at t+1, rvalid at t+2.
  - Back-to-back reads to different requesters are allowed, up to one command per cycle.
- Starvation counters (CPU, KBD):
  - Increment in each cycle the owner's req=1, it is eligible, and it loses arbitration. They saturate at STARVE_MAX.
  - Reset to 0 on that owner's grant or when its req=0.
- Boundaries:
  - With a single requester holding req continuously, it receives a grant every other cycle.
  - Writes and reads never occur in the same cycle; mem_we and mem_re are mutually exclusive.
  - Address width is passed through unchanged; no wrap or range check is performed (memory decodes the address).

Decomposition:
- Package calc_mem_pkg holds:
  - typedef enum logic [1:0] {SRC_NONE, SRC_VGA, SRC_CPU, SRC_KBD} mem_src_t;
  - the default STARVE_MAX constant;
  - the KBD zero-extension width constant (5).
- One sub-module, starve_counter: saturating counter with inc/clr inputs and a sat output, instantiated once for CPU and once for KBD.

Test Plan:
- Reset asserted mid-read (VGA read granted, reset=0 before t+2): no vga_rvalid is produced, all outputs read 0, and the first request after reset is granted normally.
- VGA read at addr 0x10 with mem_rdata=0xCAFE0001 driven at t+2: vga_gnt at t+1, mem_re=1 with mem_addr=0x10, then vga_rvalid=1 with vga_rdata=0xCAFE0001 at t+2.
- CPU store addr 0x20, data 0x12345678, alone: cpu_gnt one cycle, mem_we=1 with matching addr/data, no cpu_rvalid.
- VGA, CPU and KBD all requesting at t: VGA is granted first; VGA is then ineligible in its gnt cycle, so CPU wins the next arbitration (gnt at t+2), and KBD later with mem_wdata=0x0000001F for kbd_data=5'h1F and mem_addr=KBD_ADDR.
- VGA requesting continuously with KBD requesting: KBD is granted no later than the cycle after starve_kbd reaches 8, and its counter then reads 0.
- Interleaved VGA load then CPU load in consecutive grants: each rvalid reaches only its owner, with the correct data, in order.
